fp_unit_arbiter: RTL and testbench

- Shares one floating-point arithmetic unit (adder, multiplier or divider with the stb/ack operand/result handshake) among NREQ requesters in the sphere-collision datapath.
- Round-robin grant. One operation in flight at a time.
- Drives the unit's operand strobes, collects the result and returns it to the granted requester only.
- A watchdog turns a hung unit into a flagged qNaN result instead of a deadlock.

---
 rtl/fp_unit_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fp_unit_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: shares one stb/ack floating-point unit among NREQ requesters.
//   Round-robin grant, one operation in flight at a time, and a watchdog that
//   turns a hung unit into a qNaN result with a sticky err flag.
// Ports:
//   clk, rst                  clock, async active-high reset
//   req_valid/req_a/req_b     per-requester request (operands packed WIDTH per slot)
//   req_ready                 one-hot accept (combinational, IDLE only)
//   resp_valid/resp_data      one-hot result valid + shared result bus
//   resp_ready                per-requester result consume
//   unit_a/b, unit_a/b_stb    operands + strobes to the shared unit
//   unit_a/b_ack              operand acks from the unit
//   unit_z, unit_z_stb        unit result + strobe
//   unit_z_ack                one-cycle result ack
//   busy, grant_id, err       status: not IDLE, current/last grant, sticky timeout
module fp_unit_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           resp_valid,
  output logic [WIDTH-1:0]          resp_data,
  input  logic [NREQ-1:0]           resp_ready,
  output logic [WIDTH-1:0]          unit_a,
  output logic [WIDTH-1:0]          unit_b,
  output logic                      unit_a_stb,
  output logic                      unit_b_stb,
  input  logic                      unit_a_ack,
  input  logic                      unit_b_ack,
  input  logic [WIDTH-1:0]          unit_z,
  input  logic                      unit_z_stb,
  output logic                      unit_z_ack,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      err
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7FC0_0000);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             a_stb_q, a_stb_d, b_stb_q, b_stb_d;
  logic             zack_q, zack_d, err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             hit;
  logic [IDW-1:0]   sel, cand;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_q) + k) % NREQ);
      if (!hit && req_valid[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && hit) req_ready[sel] = 1'b1;
    resp_valid = '0;
    if (state_q == S_DELIVER) resp_valid[gid_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    a_stb_d = a_stb_q;
    b_stb_d = b_stb_q;
    zack_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (hit) begin
        a_d     = req_a[int'(sel)*WIDTH +: WIDTH];
        b_d     = req_b[int'(sel)*WIDTH +: WIDTH];
        gid_d   = sel;
        a_stb_d = 1'b1;
        b_stb_d = 1'b1;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Each strobe retires on its own ack; the strobe itself records completion.
        if (a_stb_q && unit_a_ack) a_stb_d = 1'b0;
        if (b_stb_q && unit_b_ack) b_stb_d = 1'b0;
        if (!a_stb_d && !b_stb_d) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (unit_z_stb) begin
          res_d   = unit_z;
          zack_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_DELIVER;
        end else if (cnt_q == TO_LAST) begin
          // Hung unit: return qNaN and flag it; no ack since nothing arrived.
          res_d   = QNAN;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DELIVER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: if (resp_ready[gid_q]) begin
        last_d  = gid_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      gid_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      a_stb_q <= 1'b0;
      b_stb_q <= 1'b0;
      zack_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      a_stb_q <= a_stb_d;
      b_stb_q <= b_stb_d;
      zack_q  <= zack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign unit_a_stb = a_stb_q;
  assign unit_b_stb = b_stb_q;
  assign unit_z_ack = zack_q;
  assign resp_data  = res_q;
  assign busy       = (state_q != S_IDLE);
  assign grant_id   = gid_q;
  assign err        = err_q;
endmodule

// File: tb/tb_fp_unit_arbiter.sv
module tb_fp_unit_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TO   = 16;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] F0_5 = 32'h3F00_0000, F1 = 32'h3F80_0000, F2 = 32'h4000_0000,
                          F3 = 32'h4040_0000, F4 = 32'h4080_0000, F5 = 32'h40A0_0000,
                          F6 = 32'h40C0_0000, F7 = 32'h40E0_0000, F8 = 32'h4100_0000;

  logic                  clk, rst;
  logic [NREQ-1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [NREQ*W-1:0]     req_a, req_b;
  logic [W-1:0]          resp_data, unit_a, unit_b, unit_z;
  logic                  unit_a_stb, unit_b_stb, unit_a_ack, unit_b_ack;
  logic                  unit_z_stb, unit_z_ack, busy, err;
  logic [1:0]            grant_id;

  fp_unit_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_ready(resp_ready), .unit_a(unit_a), .unit_b(unit_b),
    .unit_a_stb(unit_a_stb), .unit_b_stb(unit_b_stb), .unit_a_ack(unit_a_ack),
    .unit_b_ack(unit_b_ack), .unit_z(unit_z), .unit_z_stb(unit_z_stb),
    .unit_z_ack(unit_z_ack), .busy(busy), .grant_id(grant_id), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Single-precision <-> real for the exactly-representable values used here.
  function automatic real f2r(logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic int oh_idx(logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { int id; logic [31:0] data; } exp_t;
  exp_t sb[$];
  int   gq[$];
  logic hang = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rdy_onehot0", 64'($onehot0(req_ready)), 1);
      if (busy) chk("rdy_while_busy", req_ready, 0);
      if (|(req_valid & req_ready)) begin
        exp_t e;
        e.id   = oh_idx(req_valid & req_ready);
        e.data = hang ? QNAN : fadd(req_a[e.id*W +: W], req_b[e.id*W +: W]);
        sb.push_back(e);
        gq.push_back(e.id);
      end
      if (|(resp_valid & resp_ready)) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_onehot", resp_valid, 64'(4'b0001 << e.id));
          chk("resp_data", resp_data, e.data);
          chk("resp_grant_id", grant_id, 64'(e.id));
        end
      end
    end
  end

  // ---------------- unit model ----------------
  int a_dly = 0, b_dly = 0, lat = 4, ops = 0;
  logic [31:0] opa, opb;

  task automatic ack_a();
    opa = unit_a;
    repeat (a_dly) begin
      chk("a_stb_held", unit_a_stb, 1);
      chk("a_stable", unit_a, opa);
      @(posedge clk); #1;
    end
    unit_a_ack = 1'b1;
    @(posedge clk); #1;
    unit_a_ack = 1'b0;
    chk("a_stb_drop", unit_a_stb, 0);
  endtask

  task automatic ack_b();
    opb = unit_b;
    repeat (b_dly) begin
      chk("b_stb_held", unit_b_stb, 1);
      chk("b_stable", unit_b, opb);
      @(posedge clk); #1;
    end
    unit_b_ack = 1'b1;
    @(posedge clk); #1;
    unit_b_ack = 1'b0;
    chk("b_stb_drop", unit_b_stb, 0);
  endtask

  task automatic produce();
    int n;
    repeat (lat - 1) begin @(posedge clk); #1; end
    unit_z     = fadd(opa, opb);
    unit_z_stb = 1'b1;
    n = 0;
    forever begin
      @(posedge clk); #1;
      if (unit_z_ack) break;
      n++;
      if (n > 20) begin chk("z_ack_seen", 0, 1); break; end
    end
    unit_z_stb = 1'b0;
    @(posedge clk); #1;
    chk("z_ack_pulse", unit_z_ack, 0);
  endtask

  initial begin : unit_model
    unit_a_ack = 1'b0; unit_b_ack = 1'b0; unit_z_stb = 1'b0; unit_z = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && (unit_a_stb || unit_b_stb)) begin
        ops++;
        fork
          ack_a();
          ack_b();
        join
        if (!hang) produce();
      end
    end
  end

  // ---------------- requester helpers ----------------
  int last_wait [NREQ];

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i] = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready[i]) break;
      w++;
      if (w > 2000) begin chk("accept_timeout", 0, 1); break; end
    end
    last_wait[i] = w;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!busy && sb.size() == 0 && req_valid == '0) break;
      n++;
      if (n > 2000) begin chk("idle_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int i);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (resp_valid[i]) break;
      n++;
      if (n > 500) begin chk("resp_timeout", 0, 1); break; end
    end
  endtask

  task automatic wait_in_wait();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (busy && !unit_a_stb && !unit_b_stb && resp_valid == '0) break;
      n++;
      if (n > 500) begin chk("wait_state_timeout", 0, 1); break; end
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int wcnt;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_stbs", {unit_a_stb, unit_b_stb, unit_z_ack}, 0);
    chk("rst_grant_err", {grant_id, err}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: lone requester 2, zero-cycle accept, 1.0 + 2.0
    issue(2, F1, F2);
    chk("t1_accept_lat", last_wait[2], 0);
    wait_resp(2);
    chk("t1_data", resp_data, F3);
    wait_idle();
    chk("t1_grant_id", grant_id, 2);
    chk("t1_err", err, 0);

    // z strobe outside WAIT is ignored
    unit_z = 32'hDEAD_BEEF; unit_z_stb = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("z_idle_noack", unit_z_ack, 0);
      chk("z_idle_busy", busy, 0);
    end
    unit_z_stb = 1'b0;
    @(posedge clk); #1;

    // 2: all four contend, order 0,1,2,3,0
    pulse_rst();
    gq.delete();
    fork
      begin issue(0, F1, F1); issue(0, F8, F0_5); end
      issue(1, F2, F3);
      issue(2, F4, F5);
      issue(3, F6, F7);
    join
    wait_idle();
    chk("t2_grants", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++)
      chk($sformatf("t2_grant%0d", k), gq[k], k % 4);

    // 3: a acked at once, b three cycles later
    a_dly = 0; b_dly = 3;
    wcnt = ops;
    issue(1, F7, F0_5);
    wait_idle();
    chk("t3_one_op", ops, wcnt + 1);
    b_dly = 0;

    // 4: requester 1 stalls its response for 10 cycles, requester 0 waits
    resp_ready[1] = 1'b0;
    issue(1, F3, F4);
    fork issue(0, F5, F5); join_none
    wait_resp(1);
    repeat (10) begin
      @(negedge clk);
      chk("t4_valid_held", resp_valid, 4'b0010);
      chk("t4_data_held", resp_data, F7);
      chk("t4_busy", busy, 1);
      chk("t4_no_ready", req_ready, 0);
    end
    resp_ready[1] = 1'b1;
    wait_idle();

    // 5: hung unit -> qNaN after TIMEOUT cycles in WAIT, sticky err
    hang = 1'b1;
    issue(3, F5, F6);
    wcnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (resp_valid != '0) break;
      if (busy && !unit_a_stb && !unit_b_stb) wcnt++;
    end
    chk("t5_wait_cycles", wcnt, TO);
    chk("t5_qnan", resp_data, QNAN);
    chk("t5_err", err, 1);
    wait_idle();
    hang = 1'b0;
    issue(0, F2, F2);
    wait_idle();
    chk("t5_err_sticky", err, 1);

    // 6: reset during WAIT aborts; requester 0 wins first afterward
    hang = 1'b1;
    issue(2, F1, F1);
    wait_in_wait();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_resp_valid", resp_valid, 0);
    chk("t6_outs", {unit_a_stb, unit_b_stb, unit_z_ack, err}, 0);
    chk("t6_unit_a", unit_a, 0);
    chk("t6_grant_id", grant_id, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    hang = 1'b0;
    gq.delete();
    fork
      issue(1, F2, F6);
      issue(0, F3, F5);
    join
    wait_idle();
    chk("t6_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("t6_err_clear", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
